// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: realigns fetch PC with next-cycle BRAM data.
// Optional IF_ID_PERF_EN adds saturating stall/flush event counters.
`timescale 1ns/1ps
module if_id_pipe #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            f_valid,
    input  logic [XLEN-1:0] f_pc,
    input  logic [XLEN-1:0] f_pcplus4,
    input  logic [XLEN-1:0] f_instr,
    output logic            d_valid,
    output logic [XLEN-1:0] d_pc,
    output logic [XLEN-1:0] d_pcplus4,
    output logic [XLEN-1:0] d_instr
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam logic [XLEN-1:0] RESET_PC4 = RESET_PC + XLEN'(4);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic            held;
        logic [XLEN-1:0] instr;
    } a_slot_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic [XLEN-1:0] instr;
    } d_slot_t;

    a_slot_t a_q, a_d;
    d_slot_t d_q, d_d;

    logic [XLEN-1:0] instr_sel;

    // A held word wins over the live BRAM output once captured in a stall.
    assign instr_sel = a_q.held ? a_q.instr : f_instr;

    always_comb begin
        a_d = a_q;
        d_d = d_q;
        if (flush) begin
            a_d.valid = 1'b0;
            a_d.held  = 1'b0;
            d_d.valid = 1'b0;
            d_d.instr = NOP_INSTR;
        end else if (stall) begin
            if (a_q.valid && !a_q.held) begin
                a_d.instr = f_instr;
                a_d.held  = 1'b1;
            end
        end else begin
            d_d.valid   = a_q.valid;
            d_d.pc      = a_q.pc;
            d_d.pcplus4 = a_q.pcplus4;
            d_d.instr   = a_q.valid ? instr_sel : NOP_INSTR;
            a_d.valid   = f_valid;
            a_d.pc      = f_pc;
            a_d.pcplus4 = f_pcplus4;
            a_d.held    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q.valid   <= 1'b0;
            a_q.pc      <= RESET_PC;
            a_q.pcplus4 <= RESET_PC4;
            a_q.held    <= 1'b0;
            a_q.instr   <= NOP_INSTR;
            d_q.valid   <= 1'b0;
            d_q.pc      <= RESET_PC;
            d_q.pcplus4 <= RESET_PC4;
            d_q.instr   <= NOP_INSTR;
        end else begin
            a_q <= a_d;
            d_q <= d_d;
        end
    end

    assign d_valid   = d_q.valid;
    assign d_pc      = d_q.pc;
    assign d_pcplus4 = d_q.pcplus4;
    assign d_instr   = d_q.instr;

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && d_q.valid && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (a_q.valid || d_q.valid) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    // Counters absent; the pipeline path is identical.
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed bench for if_id_pipe: reset, streaming, stall, flush, perf.
`timescale 1ns/1ps
module tb_if_id_pipe;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_pcplus4;
    logic [31:0] f_instr;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [31:0] d_pcplus4;
    logic [31:0] d_instr;
`ifdef IF_ID_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_id_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .f_valid   (f_valid),
        .f_pc      (f_pc),
        .f_pcplus4 (f_pcplus4),
        .f_instr   (f_instr),
        .d_valid   (d_valid),
        .d_pc      (d_pc),
        .d_pcplus4 (d_pcplus4),
        .d_instr   (d_instr)
`ifdef IF_ID_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [31:0] pc);
        f_valid   = v;
        f_pc      = pc;
        f_pcplus4 = pc + 32'd4;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic v,
                         input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, ".valid"}, {31'd0, d_valid}, {31'd0, v});
        chk({tag, ".pc"}, d_pc, pc);
        chk({tag, ".pc4"}, d_pcplus4, pc + 32'd4);
        chk({tag, ".instr"}, d_instr, ins);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        issue(1'b0, 32'h0);
        f_instr = 32'h0;
        #1;
        chk_d("rst0", 1'b0, 32'h0, NOP);
        rst = 1'b0;
        tick();
        tick();
        chk_d("rst_rel", 1'b0, 32'h0, NOP);

        // streaming fetch 0,4,8
        issue(1'b1, 32'h0);
        tick();
        issue(1'b1, 32'h4);
        f_instr = 32'h0050_0093;
        tick();
        chk_d("s0", 1'b1, 32'h0, 32'h0050_0093);
        issue(1'b1, 32'h8);
        f_instr = 32'h0010_0113;
        tick();
        chk_d("s4", 1'b1, 32'h4, 32'h0010_0113);
        issue(1'b0, 32'h8);
        f_instr = 32'h0020_81B3;
        tick();
        chk_d("s8", 1'b1, 32'h8, 32'h0020_81B3);
        f_instr = 32'hDEAD_BEEF;
        tick();
        chk("bubble.valid", {31'd0, d_valid}, 32'd0);
        chk("bubble.instr", d_instr, NOP);

        // stall capture with pc=4 in flight
        issue(1'b1, 32'h0);
        tick();
        issue(1'b1, 32'h4);
        f_instr = 32'h0050_0093;
        tick();
        stall = 1'b1;
        issue(1'b1, 32'h8);
        f_instr = 32'h0010_0113;
        tick();
        chk_d("st1", 1'b1, 32'h0, 32'h0050_0093);
        f_instr = 32'hDEAD_BEEF;
        tick();
        tick();
        chk_d("st3", 1'b1, 32'h0, 32'h0050_0093);
        stall = 1'b0;
        tick();
        chk_d("st_rel", 1'b1, 32'h4, 32'h0010_0113);
        issue(1'b1, 32'hC);
        f_instr = 32'h0020_81B3;
        tick();
        chk_d("st_next", 1'b1, 32'h8, 32'h0020_81B3);

        // flush with both slots valid (D=8, A=C)
        flush = 1'b1;
        issue(1'b1, 32'h10);
        f_instr = 32'h1234_5678;
        tick();
        chk_d("fl", 1'b0, 32'h8, NOP);
        flush = 1'b0;
        issue(1'b1, 32'h40);
        f_instr = 32'hCAFE_F00D;
        tick();
        chk_d("fl_drop", 1'b0, 32'hC, NOP);
        issue(1'b0, 32'h0);
        f_instr = 32'h0000_0537;
        tick();
        chk_d("fl_40", 1'b1, 32'h40, 32'h0000_0537);

        // flush and stall together
        issue(1'b1, 32'h50);
        tick();
        issue(1'b1, 32'h54);
        f_instr = 32'hAAAA_0001;
        tick();
        chk_d("fs_pre", 1'b1, 32'h50, 32'hAAAA_0001);
        flush = 1'b1;
        stall = 1'b1;
        f_instr = 32'hAAAA_0002;
        tick();
        chk_d("fs", 1'b0, 32'h50, NOP);
        flush = 1'b0;
        tick();
        chk_d("fs_stall", 1'b0, 32'h50, NOP);
        stall = 1'b0;
        issue(1'b0, 32'h0);
        tick();
        chk_d("fs_rel", 1'b0, 32'h54, NOP);
        tick();
        chk("fs_none.valid", {31'd0, d_valid}, 32'd0);

        // reset mid-stall discards held word
        issue(1'b1, 32'h60);
        tick();
        issue(1'b0, 32'h0);
        stall = 1'b1;
        f_instr = 32'h1111_1111;
        tick();
        rst = 1'b1;
        #1;
        chk_d("rst_mid", 1'b0, 32'h0, NOP);
        rst = 1'b0;
        stall = 1'b0;
        f_instr = 32'h2222_2222;
        tick();
        chk_d("rst_after", 1'b0, 32'h0, NOP);

`ifdef IF_ID_PERF_EN
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("perf_rst.stall", perf_stall_cnt, 32'd0);
        chk("perf_rst.flush", perf_flush_cnt, 32'd0);
        issue(1'b1, 32'h0);
        tick();
        issue(1'b1, 32'h4);
        f_instr = 32'h0050_0093;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("perf.stall5", perf_stall_cnt, 32'd5);
        stall = 1'b0;
        issue(1'b0, 32'h0);
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        issue(1'b1, 32'h80);
        tick();
        flush = 1'b1;
        issue(1'b0, 32'h0);
        tick();
        flush = 1'b0;
        chk("perf.flush2", perf_flush_cnt, 32'd2);
        chk("perf.stall_keep", perf_stall_cnt, 32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_pipe.md
Name: if_id_pipe

Overview:
- IF/ID pipeline register for the 5-stage RISC-V core. It sits between the fetch stage and the decode stage.
- Re-aligns fetch's PC/PC+4 with the instruction-memory read data, which arrives one cycle later from the synchronous BRAM.
- Supports stall (hold) and flush (squash) from the hazard unit.
- Guarantees decode sees a NOP whenever its slot is invalid.

Parameters:
- XLEN, 32, datapath width of pc/pcplus4/instr.
- NOP_INSTR, 32'h0000_0013, instruction presented when a slot is invalid (addi x0,x0,0).
- RESET_PC, 32'h0000_0000, value of d_pc / d_pcplus4 at reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  hold both internal slots (fetch is also stalled).
- flush  in  1  squash both internal slots (branch/jump redirect).
- f_valid  in  1  fetch issued a BRAM read this cycle for f_pc.
- f_pc  in  XLEN  address of the read issued this cycle.
- f_pcplus4  in  XLEN  f_pc+4 from fetch.
- f_instr  in  XLEN  BRAM douta: data for the address issued the previous cycle.
- d_valid  out  1  decode slot holds a real instruction.
- d_pc  out  XLEN  PC of the decode-slot instruction.
- d_pcplus4  out  XLEN  PC+4 of the decode-slot instruction.
- d_instr  out  XLEN  instruction to decode; NOP_INSTR when d_valid=0.

Behaviour:
- Two registered slots:
  - A (in-flight): a_valid, a_pc, a_pcplus4, a_held, a_instr. A tracks the read whose data is on f_instr this cycle.
  - D (output): d_valid, d_pc, d_pcplus4, d_instr.
- Reset (async, rst=1):
  - a_valid=0, a_held=0.
  - d_valid=0, d_pc=RESET_PC, d_pcplus4=RESET_PC+4, d_instr=NOP_INSTR.
  - Outputs change immediately on assertion, without waiting for a clock edge.
- Latency: an instruction accepted with f_valid=1 at edge N appears on the d_* outputs after edge N+1 (2-cycle fetch-to-decode), provided there is no stall or flush.
- Priority per edge: flush > stall > advance.
- Advance (stall=0, flush=0):
  - D <= {a_valid, a_pc, a_pcplus4, instr_sel}.
  - instr_sel = a_held ? a_instr : f_instr. When a_valid=0, D takes NOP_INSTR instead.
  - A <= {f_valid, f_pc, f_pcplus4}, with a_held=0.
- Stall (stall=1, flush=0):
  - D holds all fields.
  - A holds pc/pcplus4/valid.
  - If a_valid=1 and a_held=0: a_instr <= f_instr and a_held <= 1, so the BRAM word is captured on the first stall cycle.
  - Subsequent stall cycles do not overwrite a_instr.
- Flush (flush=1, regardless of stall):
  - a_valid <= 0, a_held <= 0.
  - d_valid <= 0, d_instr <= NOP_INSTR.
  - d_pc and d_pcplus4 hold their values.
  - The fetch issuing on the flush cycle is discarded.
- Edge cases:
  - f_valid=0 with stall=0: creates a bubble; d_valid=0 one cycle later.
  - Back-to-back stalls of any length: no data loss. On release, D receives the held word, not the current f_instr.
  - Flush on the cycle stall deasserts: flush wins.
  - Reset mid-stall: all held state is discarded.
- d_instr is NOP_INSTR whenever d_valid=0; this is a registered invariant.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0.
  - perf_stall_cnt increments on each edge with stall=1 and d_valid=1.
  - perf_flush_cnt increments on each edge with flush=1 that kills at least one valid slot (a_valid|d_valid).
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Test Plan:
- Reset: rst=1 mid-run -> d_valid=0, d_pc=0, d_pcplus4=4, d_instr=32'h13 with no clock edge; after release with f_valid=0, outputs stay the same.
- Streaming fetch:
  - Stimulus: f_pc=0,4,8 on consecutive cycles; BRAM returns 32'h00500093, 32'h00100113, 32'h002081B3 one cycle later.
  - Required: d_pc=0,4,8 with the matching d_instr two edges after each issue, and d_valid=1.
- Stall capture:
  - Stimulus: stall held 3 cycles while f_instr toggles to garbage 32'hDEADBEEF after the first stall cycle.
  - Required: on release, D gets the captured word 32'h00100113 for pc=4, not garbage.
- Flush:
  - Stimulus: flush for 1 cycle with both slots valid.
  - Required: next cycle d_valid=0, d_instr=32'h13; the following issue at f_pc=0x40 appears with d_pc=0x40 two edges later.
- Flush+stall: both asserted together -> both slots invalidated; no instruction is replayed after stall drops.
- With IF_ID_PERF_EN defined:
  - 5 stall cycles with d_valid=1 -> perf_stall_cnt=5.
  - 2 flushes with valid slots plus 1 flush with empty slots -> perf_flush_cnt=2.
